comparator_stim_checker: RTL and testbench

//  Self-checking driver/monitor for the far end of comparator_n_bit's interface.
//  - Generates operand pairs and drives them onto a/b.
//  - Samples L/G/E after a settle window and checks them against an internally computed expected result.
//  - Reports error and vector counts, plus a pass flag.
//  - Used on-chip (BIST) and in sim to qualify any comparator_n_bit build.

---
 rtl/cmpchk_pkg.sv | 30 +++
 rtl/cmpchk_lfsr.sv | 32 +++
 rtl/comparator_stim_checker.sv | 184 ++++++++++++++++++
 tb/tb_comparator_stim_checker.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cmpchk_pkg.sv
// cmpchk_pkg: shared types and constants for comparator_stim_checker.
//   state_e       : checker FSM states
//   LFSR_POLY     : Galois feedback mask for x^32+x^22+x^2+x+1 (right-shifting form)
//   VEC_*         : indices of the fixed corner-case vectors
//   ERR_MAX       : saturation value of the error counter
//   lfsr_next()   : one Galois LFSR step
package cmpchk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } state_e;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  localparam logic [15:0] VEC_ZERO    = 16'd0;  // a=0,      b=0
  localparam logic [15:0] VEC_A0_B1   = 16'd1;  // a=0,      b=ones
  localparam logic [15:0] VEC_A1_B0   = 16'd2;  // a=ones,   b=0
  localparam logic [15:0] VEC_EQ_RAND = 16'd3;  // a=b=LFSR_A; first LFSR-driven vector

  localparam logic [15:0] ERR_MAX = 16'hFFFF;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0000_0000);
  endfunction

endpackage

// File: rtl/cmpchk_lfsr.sv
// cmpchk_lfsr: 32-bit Galois LFSR with a seed parameter.
//   clk     in  rising-edge clock
//   rst     in  asynchronous active-high reset; reloads SEED
//   en_i    in  advance one step on this clock edge
//   state_o out current LFSR state
module cmpchk_lfsr
  import cmpchk_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_2468
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  output logic [31:0] state_o
);

  logic [31:0] state_q;
  logic [31:0] state_d;

  always_comb begin
    state_d = state_q;
    if (en_i) state_d = lfsr_next(state_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SEED;
    else     state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/comparator_stim_checker.sv
// comparator_stim_checker: drives operand pairs to a comparator_n_bit instance,
// samples its L/G/E flags after a settle window and checks them against the
// locally computed unsigned compare result.
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active-high
//   start      in   1-cycle pulse; starts a run from IDLE or DONE
//   a_out      out  N-bit operand A
//   b_out      out  N-bit operand B
//   L_in       in   DUT a<b flag
//   G_in       in   DUT a>b flag
//   E_in       in   DUT a==b flag
//   busy       out  high in DRIVE/WAIT/CHECK
//   done       out  high in DONE
//   pass       out  high in DONE when no mismatch was seen
//   err_count  out  mismatching vectors (saturating)
//   vec_count  out  vectors checked this run
// Build option: CMPCHK_STOP_ON_FAIL_EN -- first mismatch ends the run, with
// a_out/b_out frozen on the failing pair.
module comparator_stim_checker
  import cmpchk_pkg::*;
#(
  parameter int unsigned N           = 32,
  parameter int unsigned NUM_VECTORS = 16,
  parameter int unsigned SETTLE      = 2,
  parameter logic [31:0] SEED        = 32'hACE1_2468
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic [N-1:0] a_out,
  output logic [N-1:0] b_out,
  input  logic         L_in,
  input  logic         G_in,
  input  logic         E_in,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [15:0]  err_count,
  output logic [15:0]  vec_count
);

  localparam logic [15:0] NUM_VEC16   = 16'(NUM_VECTORS);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);

  state_e      state_q, state_d;
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;
  logic [15:0] vec_q, vec_d;
  logic [15:0] err_q, err_d;
  logic [15:0] settle_q, settle_d;

  logic        lfsr_en;
  logic [31:0] lfsr_a;
  logic [31:0] lfsr_b;

  logic [N-1:0] vec_a;
  logic [N-1:0] vec_b;
  logic [2:0]   exp_flags;
  logic [2:0]   obs_flags;
  logic         mismatch;

  cmpchk_lfsr #(.SEED(SEED)) u_lfsr_a (
    .clk     (clk),
    .rst     (rst),
    .en_i    (lfsr_en),
    .state_o (lfsr_a)
  );

  cmpchk_lfsr #(.SEED(~SEED)) u_lfsr_b (
    .clk     (clk),
    .rst     (rst),
    .en_i    (lfsr_en),
    .state_o (lfsr_b)
  );

  // Vector selection: three fixed corners, one equal pair, then LFSR pairs.
  always_comb begin
    vec_a = '0;
    vec_b = '0;
    case (vec_q)
      VEC_ZERO: begin
        vec_a = '0;
        vec_b = '0;
      end
      VEC_A0_B1: begin
        vec_a = '0;
        vec_b = '1;
      end
      VEC_A1_B0: begin
        vec_a = '1;
        vec_b = '0;
      end
      VEC_EQ_RAND: begin
        vec_a = lfsr_a[N-1:0];
        vec_b = lfsr_a[N-1:0];
      end
      default: begin
        vec_a = lfsr_a[N-1:0];
        vec_b = lfsr_b[N-1:0];
      end
    endcase
  end

  // Any deviation from the exact one-hot expectation counts, so a DUT that
  // raises two flags or none is caught as well.
  always_comb begin
    exp_flags = {a_q < b_q, a_q > b_q, a_q == b_q};
    obs_flags = {L_in, G_in, E_in};
    mismatch  = (obs_flags != exp_flags);
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    vec_d    = vec_q;
    err_d    = err_q;
    settle_d = settle_q;
    lfsr_en  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          vec_d   = '0;
          err_d   = '0;
          state_d = ST_DRIVE;
        end
      end

      ST_DRIVE: begin
        a_d      = vec_a;
        b_d      = vec_b;
        settle_d = '0;
        // LFSRs advance together with each vector that consumes them.
        lfsr_en  = (vec_q >= VEC_EQ_RAND);
        state_d  = ST_WAIT;
      end

      ST_WAIT: begin
        settle_d = settle_q + 16'd1;
        if (settle_q == SETTLE_LAST) state_d = ST_CHECK;
      end

      ST_CHECK: begin
        vec_d = vec_q + 16'd1;
        if (mismatch && (err_q != ERR_MAX)) err_d = err_q + 16'd1;
        if (vec_d == NUM_VEC16) state_d = ST_DONE;
        else                    state_d = ST_DRIVE;
`ifdef CMPCHK_STOP_ON_FAIL_EN
        if (mismatch) state_d = ST_DONE;
`endif
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      vec_q    <= '0;
      err_q    <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      vec_q    <= vec_d;
      err_q    <= err_d;
      settle_q <= settle_d;
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign busy      = (state_q == ST_DRIVE) || (state_q == ST_WAIT) || (state_q == ST_CHECK);
  assign done      = (state_q == ST_DONE);
  assign pass      = done && (err_q == '0);
  assign err_count = err_q;
  assign vec_count = vec_q;

endmodule

// File: tb/tb_comparator_stim_checker.sv
// Bench for comparator_stim_checker: a behavioural comparator (with optional
// stuck-at faults) closes the loop; expected vectors are queued at each start
// and popped whenever vec_count advances.
module tb_comparator_stim_checker;

  localparam int unsigned N  = 32;
  localparam int unsigned NV = 16;
  localparam int unsigned ST = 2;
  localparam logic [31:0] SEED = 32'hACE1_2468;
  localparam logic [31:0] POLY = 32'h8020_0003;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] a_out;
  logic [N-1:0] b_out;
  logic         L_in;
  logic         G_in;
  logic         E_in;
  logic         busy;
  logic         done;
  logic         pass;
  logic [15:0]  err_count;
  logic [15:0]  vec_count;

  int fault_mode = 0;  // 0 golden, 1 G stuck-0, 2 E stuck-0

  comparator_stim_checker #(
    .N           (N),
    .NUM_VECTORS (NV),
    .SETTLE      (ST),
    .SEED        (SEED)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a_out     (a_out),
    .b_out     (b_out),
    .L_in      (L_in),
    .G_in      (G_in),
    .E_in      (E_in),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .vec_count (vec_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    L_in = (a_out < b_out);
    G_in = (fault_mode == 1) ? 1'b0 : (a_out > b_out);
    E_in = (fault_mode == 2) ? 1'b0 : (a_out == b_out);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [15:0]  err;
    int           idx;
  } exp_t;

  exp_t sb[$];

  logic [31:0] mdl_a;
  logic [31:0] mdl_b;

  function automatic logic [31:0] step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? POLY : 32'h0);
  endfunction

  task automatic reseed();
    mdl_a = SEED;
    mdl_b = ~SEED;
  endtask

  // Queue the expected vectors of one run and return its length and final error count.
  task automatic push_run(input int mode, output int n_vec, output logic [15:0] final_err);
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [15:0]  err;
    bit           bad;
    bit           stop;
    err   = 16'd0;
    stop  = 1'b0;
    n_vec = 0;
    for (int v = 0; v < int'(NV) && !stop; v++) begin
      if (v == 0) begin
        a = '0; b = '0;
      end else if (v == 1) begin
        a = '0; b = '1;
      end else if (v == 2) begin
        a = '1; b = '0;
      end else if (v == 3) begin
        a = mdl_a[N-1:0]; b = mdl_a[N-1:0];
        mdl_a = step(mdl_a); mdl_b = step(mdl_b);
      end else begin
        a = mdl_a[N-1:0]; b = mdl_b[N-1:0];
        mdl_a = step(mdl_a); mdl_b = step(mdl_b);
      end
      bad = ((mode == 1) && (a > b)) || ((mode == 2) && (a == b));
      if (bad && (err != 16'hFFFF)) err = err + 16'd1;
      sb.push_back('{a: a, b: b, err: err, idx: v});
      n_vec++;
`ifdef CMPCHK_STOP_ON_FAIL_EN
      if (bad) stop = 1'b1;
`endif
    end
    final_err = err;
  endtask

  // Monitor: on the cycle after a CHECK edge a_out/b_out still hold the
  // vector just checked and the counters show its result.
  logic [15:0] prev_vc = 16'd0;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (!rst && (vec_count != prev_vc) && (vec_count != 16'd0)) begin
      if (sb.size() == 0) begin
        check_val("sb_underflow", 64'(vec_count), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check_val("a_out", 64'(a_out), 64'(mon_e.a));
        check_val("b_out", 64'(b_out), 64'(mon_e.b));
        check_val("vec_count", 64'(vec_count), 64'(mon_e.idx + 1));
        check_val("err_count", 64'(err_count), 64'(mon_e.err));
        if (mon_e.idx == 3) begin
          check_val("v3_equal", 64'(a_out == b_out), 64'd1);
          check_val("v3_nonzero", 64'(a_out != '0), 64'd1);
        end
      end
    end
    prev_vc = vec_count;
  end

  task automatic do_run(input int mode, input bit poke);
    int          nv;
    logic [15:0] fe;
    int          cyc;
    exp_t        last;
    fault_mode = mode;
    push_run(mode, nv, fe);
    last = sb[sb.size() - 1];
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check_val("start_busy", 64'(busy), 64'd1);
    check_val("start_vc_clr", 64'(vec_count), 64'd0);
    check_val("start_err_clr", 64'(err_count), 64'd0);
    cyc = 0;
    while (!done && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
      start = (poke && (cyc == 10 || cyc == 11 || cyc == 30)) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    check_val("run_cycles", 64'(cyc), 64'(nv * int'(ST + 2)));
    @(negedge clk);
    #1;
    check_val("done", 64'(done), 64'd1);
    check_val("busy_done", 64'(busy), 64'd0);
    check_val("final_vc", 64'(vec_count), 64'(nv));
    check_val("final_err", 64'(err_count), 64'(fe));
    check_val("pass", 64'(pass), 64'(fe == 16'd0));
    check_val("hold_a", 64'(a_out), 64'(last.a));
    check_val("hold_b", 64'(b_out), 64'(last.b));
    check_val("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_a"}, 64'(a_out), 64'd0);
    check_val({tag, "_b"}, 64'(b_out), 64'd0);
    check_val({tag, "_flags"}, 64'({busy, done, pass}), 64'd0);
    check_val({tag, "_err"}, 64'(err_count), 64'd0);
    check_val({tag, "_vc"}, 64'(vec_count), 64'd0);
  endtask

  task automatic reset_mid_run();
    int          nv;
    logic [15:0] fe;
    fault_mode = 0;
    push_run(0, nv, fe);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    // v5 DRIVE is the 21st state after the start edge; one more edge puts it in WAIT.
    repeat (21) @(posedge clk);
    #2;
    check_val("pre_rst_vc", 64'(vec_count), 64'd5);
    check_val("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    sb.delete();
    reseed();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    reseed();
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("idle");

    do_run(0, 1'b0);   // golden comparator
    do_run(1, 1'b1);   // G stuck-0, start pulsed while busy
    do_run(2, 1'b0);   // E stuck-0, started from DONE
    reset_mid_run();
    do_run(0, 1'b0);   // after reseed: sequence must restart from v0 with seed values

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
